// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer (start detect, edge/bit counters, datapath enables, frame status).
// Optional break detection is compiled in with `define UART_RX_BREAK_DET_EN.
`timescale 1ns/1ps
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  sampled_bit,
    input  logic                  par_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  data_valid,
    output logic                  par_err_pulse,
    output logic                  frm_err_pulse,
    output logic                  break_det
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [3:0]            LAST_DATA_BIT = 4'(DATA_WIDTH);
    localparam logic [PRESCALE_W-1:0] ONE           = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO           = PRESCALE_W'(2);

    state_t                  state, next_state;
    logic [PRESCALE_W-1:0]   presc_q, last_edge, pen_edge, edge_cnt_nx;
    logic [3:0]              bit_cnt_nx;
    logic                    par_en_q, par_flag, par_flag_nx;
    logic                    at_last, frame_start, brk_hold;
    logic                    dat_samp_en_nx, deser_en_nx, par_chk_en_nx;
    logic                    data_valid_nx, par_err_pulse_nx, frm_err_pulse_nx;
`ifdef UART_RX_BREAK_DET_EN
    logic                    data_or, data_or_nx, brk_hold_nx, break_nx;
    logic [PRESCALE_W-1:0]   hi_cnt, hi_cnt_nx;
`else
    assign brk_hold  = 1'b0;
    assign break_det = 1'b0;
`endif

    // Bit timing uses the prescale latched at frame start, not the live input.
    assign last_edge   = presc_q - ONE;
    assign pen_edge    = presc_q - TWO;
    assign at_last     = (edge_cnt == last_edge);
    assign frame_start = (state == IDLE) && (next_state == START);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN && !brk_hold) next_state = START;
            START:   if (at_last) next_state = sampled_bit ? IDLE : DATA;
            DATA:    if (at_last && (bit_cnt == LAST_DATA_BIT))
                         next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (at_last) next_state = STOP;
            STOP:    if (at_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        edge_cnt_nx      = '0;
        bit_cnt_nx       = '0;
        dat_samp_en_nx   = (next_state != IDLE);
        deser_en_nx      = (state == DATA) && at_last;
        par_chk_en_nx    = (state == PARITY) && (edge_cnt == pen_edge);
        data_valid_nx    = 1'b0;
        par_err_pulse_nx = 1'b0;
        frm_err_pulse_nx = 1'b0;
        par_flag_nx      = par_flag;
`ifdef UART_RX_BREAK_DET_EN
        data_or_nx       = data_or;
        break_nx         = 1'b0;
        brk_hold_nx      = brk_hold;
        hi_cnt_nx        = '0;
`endif
        if ((state != IDLE) && (next_state != IDLE)) begin
            if (at_last) begin
                bit_cnt_nx = bit_cnt + 4'd1;
            end else begin
                edge_cnt_nx = edge_cnt + ONE;
                bit_cnt_nx  = bit_cnt;
            end
        end

        if (frame_start) begin
            par_flag_nx = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            data_or_nx  = 1'b0;
`endif
        end else if ((state == STOP) && (edge_cnt == ONE) && par_en_q) begin
            par_flag_nx = par_flag | par_err;
        end

`ifdef UART_RX_BREAK_DET_EN
        if ((state == DATA) && at_last) data_or_nx = data_or | sampled_bit;
`endif

        // Framing error outranks parity; an all-zero break frame outranks framing.
        if ((state == STOP) && at_last) begin
            if (!sampled_bit) begin
`ifdef UART_RX_BREAK_DET_EN
                if (!data_or) break_nx = 1'b1;
                else          frm_err_pulse_nx = 1'b1;
`else
                frm_err_pulse_nx = 1'b1;
`endif
            end else if (par_flag) begin
                par_err_pulse_nx = 1'b1;
            end else begin
                data_valid_nx = 1'b1;
            end
        end

`ifdef UART_RX_BREAK_DET_EN
        // After a break, stay idle until the line has been high a full bit period.
        if ((state == IDLE) && brk_hold && RX_IN) begin
            if (hi_cnt == last_edge) brk_hold_nx = 1'b0;
            else                     hi_cnt_nx   = hi_cnt + ONE;
        end
        if (break_nx) brk_hold_nx = 1'b1;
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt      <= '0;
            bit_cnt       <= '0;
            presc_q       <= '0;
            par_en_q      <= 1'b0;
            par_flag      <= 1'b0;
            dat_samp_en   <= 1'b0;
            deser_en      <= 1'b0;
            par_chk_en    <= 1'b0;
            data_valid    <= 1'b0;
            par_err_pulse <= 1'b0;
            frm_err_pulse <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            data_or       <= 1'b0;
            brk_hold      <= 1'b0;
            hi_cnt        <= '0;
            break_det     <= 1'b0;
`endif
        end else begin
            if (frame_start) begin
                presc_q  <= PRESCALE;
                par_en_q <= PAR_EN;
            end
            edge_cnt      <= edge_cnt_nx;
            bit_cnt       <= bit_cnt_nx;
            par_flag      <= par_flag_nx;
            dat_samp_en   <= dat_samp_en_nx;
            deser_en      <= deser_en_nx;
            par_chk_en    <= par_chk_en_nx;
            data_valid    <= data_valid_nx;
            par_err_pulse <= par_err_pulse_nx;
            frm_err_pulse <= frm_err_pulse_nx;
`ifdef UART_RX_BREAK_DET_EN
            data_or       <= data_or_nx;
            brk_hold      <= brk_hold_nx;
            hi_cnt        <= hi_cnt_nx;
            break_det     <= break_nx;
`endif
        end
    end

endmodule
